// File: rtl/qed_dup_if.sv
// Handshake bundle between fetch, the duplicate scheduler and decode.
//   in_*      : original instruction from fetch plus its modified (duplicate) encoding
//   exec_dup  : request to switch from the original phase to the duplicate phase
//   out_*     : instruction stream toward decode, out_is_dup marks duplicates/NOPs
//   num_*     : issue counters, qed_ready flags a valid QED consistency point
// The slave modport is the scheduler's view; master is the fetch/decode side.
interface qed_dup_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_dup_instr;
  logic             exec_dup;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_is_dup;
  logic [CNT_W-1:0] num_orig;
  logic [CNT_W-1:0] num_dup;
  logic             qed_ready;

  modport slave (
    input  in_valid, in_instr, in_dup_instr, exec_dup, out_ready,
    output in_ready, out_valid, out_instr, out_is_dup, num_orig, num_dup, qed_ready
  );

  modport master (
    output in_valid, in_instr, in_dup_instr, exec_dup, out_ready,
    input  in_ready, out_valid, out_instr, out_is_dup, num_orig, num_dup, qed_ready
  );
endinterface

// File: rtl/qed_dup_scheduler.sv
// QED duplicate-instruction scheduler.
// Original phase: forwards originals to decode and queues their duplicate
// encodings. Duplicate phase: replays the queue in order, then issues NOPs
// forever. qed_ready is raised once every original has a matching duplicate.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : qed_dup_if.slave (fetch input, decode output, counters, qed_ready)
module qed_dup_scheduler #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       resetn,
  qed_dup_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ORIG,
    ST_DUP,
    ST_DONE
  } state_e;

  state_e           state_q,      state_d;
  logic             out_valid_q,  out_valid_d;
  logic [31:0]      out_instr_q,  out_instr_d;
  logic             out_is_dup_q, out_is_dup_d;
  logic [CNT_W-1:0] num_orig_q,   num_orig_d;
  logic [CNT_W-1:0] num_dup_q,    num_dup_d;
  logic             qed_ready_q,  qed_ready_d;
  logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0] count_q,      count_d;

  logic [31:0] mem_q [DEPTH];

  logic load_en;
  logic full;
  logic empty;
  logic in_ready;
  logic push;
  logic pop;

  // The single output register may take a new value when it is empty or
  // decode is consuming its current value this cycle.
  assign load_en = !out_valid_q || bus.out_ready;
  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_is_dup_d = out_is_dup_q;
    num_orig_d   = num_orig_q;
    num_dup_d    = num_dup_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    in_ready     = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    unique case (state_q)
      ST_ORIG: begin
        in_ready = !full && load_en;
        push     = bus.in_valid && in_ready;
        if (push) begin
          out_instr_d  = bus.in_instr;
          out_is_dup_d = 1'b0;
          out_valid_d  = 1'b1;
        end else if (load_en) begin
          out_valid_d  = 1'b0;
        end
        // A push in the same cycle makes the queue non-empty by the time
        // the duplicate phase starts, so it also qualifies the switch.
        if (bus.exec_dup && (!empty || push)) begin
          state_d = ST_DUP;
        end
      end

      ST_DUP: begin
        if (load_en && !empty) begin
          pop          = 1'b1;
          out_instr_d  = mem_q[rd_ptr_q];
          out_is_dup_d = 1'b1;
          out_valid_d  = 1'b1;
          if (count_q == CNT_ONE) begin
            state_d = ST_DONE;
          end
        end else if (load_en) begin
          out_valid_d = 1'b0;
        end
      end

      ST_DONE: begin
        if (load_en) begin
          out_instr_d  = NOP;
          out_is_dup_d = 1'b1;
          out_valid_d  = 1'b1;
        end
      end

      default: state_d = ST_ORIG;
    endcase

    // Push and pop are phase-exclusive, so the pointer/count updates never collide.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + CNT_ONE;
      if (num_orig_q != CNT_MAX) begin
        num_orig_d = num_orig_q + CNT_ONE;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - CNT_ONE;
      if (num_dup_q != CNT_MAX) begin
        num_dup_d = num_dup_q + CNT_ONE;
      end
    end

    // Computed from next-state values so the flag moves on the same edge
    // as the transition into DONE.
    qed_ready_d = (state_d == ST_DONE) && (num_orig_d == num_dup_d) && (num_orig_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_ORIG;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_is_dup_q <= 1'b0;
      num_orig_q   <= '0;
      num_dup_q    <= '0;
      qed_ready_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_is_dup_q <= out_is_dup_d;
      num_orig_q   <= num_orig_d;
      num_dup_q    <= num_dup_d;
      qed_ready_q  <= qed_ready_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the storage array is not reset; the occupancy count and pointers
  // define which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_dup_instr;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.out_is_dup = out_is_dup_q;
  assign bus.num_orig   = num_orig_q;
  assign bus.num_dup    = num_dup_q;
  assign bus.qed_ready  = qed_ready_q;

endmodule

// File: doc/qed_dup_scheduler.md
Name: qed_dup_scheduler

Overview:
- Sequences the QED duplicate-instruction flow between instruction fetch and the core decode stage.
- Original phase: passes original instructions to the core and queues their modified (duplicate) encodings, as produced by the instruction-modify logic, in an internal FIFO.
- Duplicate phase: on request, replays the queued duplicates in order, then issues NOPs indefinitely.
- Flags qed_ready when the duplicate count matches the original count, which is the point where the QED consistency check is valid.

Parameters:
- DEPTH, 8, duplicate FIFO entries; power of 2, >= 2.
- NOP, 32'h00000013, encoding issued once the sequence is complete (addi x0,x0,0).
- CNT_W, $clog2(DEPTH)+1, width of the issue counters; derived, do not override.

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents an original instruction
- in_ready  output  1  block accepts the original this cycle
- in_instr  input  32  original instruction
- in_dup_instr  input  32  modified encoding of in_instr, valid with in_valid
- exec_dup  input  1  request to switch to the duplicate phase (free input to formal)
- out_valid  output  1  out_instr valid toward decode
- out_ready  input  1  decode consumes out_instr (core not stalled)
- out_instr  output  32  instruction to decode
- out_is_dup  output  1  out_instr is a duplicate or a NOP
- num_orig  output  CNT_W  originals issued
- num_dup  output  CNT_W  duplicates issued
- qed_ready  output  1  sequence complete and counts equal

Behaviour:
- Reset (async assert, sync release): state=ORIG, FIFO empty with pointers=0, out_valid=0, out_instr=0, out_is_dup=0, num_orig=0, num_dup=0, qed_ready=0.
- A reset asserted mid-sequence discards all queued duplicates and counts.
- Output stage is one register. It loads when load_en = !out_valid || out_ready. Latency from an accepted input to out_valid is 1 cycle.
- If out_valid=1 and out_ready=0, out_instr and out_is_dup hold stable.
- FSM ORIG:
  - in_ready = !full && load_en.
  - On in_valid && in_ready: out_instr<=in_instr, out_is_dup<=0, out_valid<=1, in_dup_instr pushed to FIFO, num_orig++.
  - If load_en && !(in_valid && in_ready): out_valid<=0.
- ORIG -> DUP when exec_dup=1 and either the FIFO is non-empty or a push occurs this cycle.
  - A push and exec_dup in the same cycle: the push completes, then the state is DUP next cycle.
  - exec_dup with an empty FIFO and no push is ignored.
- FIFO full in ORIG: in_ready=0 and no originals are accepted until exec_dup. No forced transition.
- FSM DUP:
  - in_ready=0.
  - When load_en and the FIFO is non-empty: pop the head to out_instr, out_is_dup<=1, out_valid<=1, num_dup++.
  - DUP -> DONE on the cycle that pops the last entry.
- FSM DONE:
  - in_ready=0.
  - When load_en: out_instr<=NOP, out_is_dup<=1, out_valid<=1.
  - DONE is terminal until reset; exec_dup is ignored.
- qed_ready = (state==DONE) && (num_orig==num_dup) && (num_orig!=0). Registered, i.e. it updates on the same edge as the state change.
- FIFO: circular buffer with wrap-around pointers of width $clog2(DEPTH) plus a CNT_W occupancy count; full = (count==DEPTH).
  - ORIG only pushes and DUP only pops, so simultaneous push and pop never occurs.
- Counters saturate at DEPTH, which is never exceeded by construction.
- in_dup_instr is never inspected; its encoding correctness belongs to the modify logic.

Test Plan:
- Basic: reset, push 3 originals A,B,C with out_ready=1, exec_dup on the 4th cycle -> out sequence A,B,C (is_dup=0) then A',B',C' (is_dup=1) then NOP 32'h00000013; qed_ready=1 on the edge after C' pops; num_orig=num_dup=3.
- Full: keep in_valid=1 for 10 cycles with DEPTH=8 and no exec_dup -> exactly 8 accepted, in_ready=0 from the cycle after the 8th accept; exec_dup then drains 8 duplicates; FIFO pointer wrap verified on a second run after reset.
- Backpressure: in DUP hold out_ready=0 for 4 cycles -> out_instr/out_valid stable, num_dup unchanged; on release the next entry pops with no loss or duplication.
- exec_dup before any original -> stays ORIG, in_ready=1; exec_dup coincident with the first push -> DUP next cycle, one duplicate issued, then DONE.
- Reset mid-DUP after 2 of 5 pops -> all outputs at reset values next cycle; a fresh 1-instruction sequence completes with num_orig=num_dup=1.
- Stray exec_dup pulses in DONE -> no state change, NOP stream continues, qed_ready stays 1.
